// File: rtl/display_frame_mux.sv
// Frame-synchronous display source selector: per-field mux of live/edit/prog data, registered per frame (optional BLINK_EN cursor blank).
// Latency: frame_start at cycle n -> disp_data, mode, mode_changed valid at n+1; outputs hold between frame_start pulses.
// Backpressure: none; frame_start is the only load qualifier and every pulse (including back-to-back) is honoured.
module display_frame_mux #(
    parameter int W            = 8,
    parameter int NF           = 11,
    parameter int NT           = 3,
    parameter int BLINK_PERIOD = 30
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            escribe,
    input  logic            crono,
    input  logic            cr_activo,
    input  logic            frame_start,
    input  logic [NF*W-1:0] live_data,
    input  logic [NF*W-1:0] edit_data,
    input  logic [NF*W-1:0] prog_data,
    input  logic [7:0]      cursor,
    output logic [NF*W-1:0] disp_data,
    output logic [1:0]      mode,
    output logic            mode_changed
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EDIT = 2'd1,
        PROG = 2'd2,
        RUN  = 2'd3
    } mode_t;

    mode_t           state_q;
    mode_t           state_d;
    mode_t           req_mode;
    logic [NF*W-1:0] disp_d;

`ifdef BLINK_EN
    localparam int CW = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

    logic [CW-1:0] blink_cnt;
    logic          blink_phase;
    logic          blink_wrap;

    assign blink_wrap = (blink_cnt == CW'(BLINK_PERIOD - 1));

    // Phase used by a reload is the one registered before that frame_start.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
            if (blink_wrap) begin
                blink_phase <= ~blink_phase;
            end
        end
    end
`else
    logic unused_cursor;
    assign unused_cursor = ^cursor;
`endif

    // Clock-field prog bits and timer-field edit bits never reach the display.
    logic unused_bits;
    assign unused_bits = ^{prog_data[(NF-NT)*W-1:0], edit_data[NF*W-1 -: NT*W]};

    always_comb begin
        req_mode = IDLE;
        if (escribe) begin
            req_mode = EDIT;
        end else if (crono) begin
            req_mode = PROG;
        end else if (cr_activo) begin
            req_mode = RUN;
        end

        state_d = state_q;
        if (frame_start) begin
            state_d = req_mode;
        end

        disp_d = '0;
        for (int i = 0; i < NF; i++) begin
            if (i >= NF - NT) begin
                case (state_d)
                    PROG:    disp_d[i*W +: W] = prog_data[i*W +: W];
                    RUN:     disp_d[i*W +: W] = live_data[i*W +: W];
                    default: disp_d[i*W +: W] = '0;
                endcase
            end else begin
                if (state_d == EDIT) begin
                    disp_d[i*W +: W] = edit_data[i*W +: W];
                end else begin
                    disp_d[i*W +: W] = live_data[i*W +: W];
                end
            end
`ifdef BLINK_EN
            if (blink_phase && (state_d == EDIT || state_d == PROG) && int'(cursor) == i) begin
                disp_d[i*W +: W] = '1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            disp_data    <= '0;
            mode_changed <= 1'b0;
        end else if (frame_start) begin
            disp_data    <= disp_d;
            mode_changed <= (state_d != state_q);
        end else begin
            mode_changed <= 1'b0;
        end
    end

    assign mode = state_q;

endmodule

// File: tb/tb_display_frame_mux.sv
// Randomized bench for display_frame_mux against a frame-level reference model (blink checks under BLINK_EN).
module tb_display_frame_mux;

    localparam int W  = 8;
    localparam int NF = 11;
    localparam int NT = 3;
`ifdef BLINK_EN
    localparam int BP = 2;
`else
    localparam int BP = 30;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            escribe = 1'b0;
    logic            crono = 1'b0;
    logic            cr_activo = 1'b0;
    logic            frame_start = 1'b0;
    logic [NF*W-1:0] live_data = '0;
    logic [NF*W-1:0] edit_data = '0;
    logic [NF*W-1:0] prog_data = '0;
    logic [7:0]      cursor = 8'd0;
    logic [NF*W-1:0] disp_data;
    logic [1:0]      mode;
    logic            mode_changed;

    int checks = 0;
    int errors = 0;

    // Reference state: what the display should show right now.
    int              m_mode = 0;
    logic [NF*W-1:0] m_disp = '0;
    logic            m_chg = 1'b0;
    int              m_frames = 0;

    display_frame_mux #(.W(W), .NF(NF), .NT(NT), .BLINK_PERIOD(BP)) dut (
        .clk          (clk),
        .reset        (reset),
        .escribe      (escribe),
        .crono        (crono),
        .cr_activo    (cr_activo),
        .frame_start  (frame_start),
        .live_data    (live_data),
        .edit_data    (edit_data),
        .prog_data    (prog_data),
        .cursor       (cursor),
        .disp_data    (disp_data),
        .mode         (mode),
        .mode_changed (mode_changed)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int requested();
        if (escribe)   return 1;
        if (crono)     return 2;
        if (cr_activo) return 3;
        return 0;
    endfunction

    function automatic logic [NF*W-1:0] frame_image(input int md, input int frame_no);
        logic [NF*W-1:0] img;
        logic [W-1:0]    v;
        bit              tmr;
        img = '0;
        for (int f = 0; f < NF; f++) begin
            tmr = (f >= NF - NT);
            case (md)
                1:       v = tmr ? '0 : edit_data[f*W +: W];
                2:       v = tmr ? prog_data[f*W +: W] : live_data[f*W +: W];
                3:       v = live_data[f*W +: W];
                default: v = tmr ? '0 : live_data[f*W +: W];
            endcase
`ifdef BLINK_EN
            // Blank half-periods are the odd-numbered groups of BP frames since reset.
            if ((md == 1 || md == 2) && (((frame_no - 1) / BP) % 2 == 1) && int'(cursor) == f)
                v = '1;
`else
            if (frame_no < 0) v = '1;
`endif
            img[f*W +: W] = v;
        end
        return img;
    endfunction

    // One clock: model consumes the inputs presented at the edge, then outputs are compared.
    task automatic tick();
        int nm;
        @(posedge clk);
        if (reset) begin
            m_mode = 0; m_disp = '0; m_chg = 1'b0; m_frames = 0;
        end else if (frame_start) begin
            nm = requested();
            m_frames++;
            m_chg  = (nm != m_mode);
            m_mode = nm;
            m_disp = frame_image(nm, m_frames);
        end else begin
            m_chg = 1'b0;
        end
        #1;
        check_val("disp_data", 128'(disp_data), 128'(m_disp));
        check_val("mode", 128'(mode), 128'(m_mode));
        check_val("mode_changed", 128'(mode_changed), 128'(m_chg));
    endtask

    function automatic logic [NF*W-1:0] rand_bus();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[NF*W-1:0];
    endfunction

    initial begin
        // Reset state
        reset = 1'b1;
        tick();
        check_val("rst_disp", 128'(disp_data), 128'h0);
        check_val("rst_mode", 128'(mode), 128'h0);

        // IDLE -> IDLE load
        reset = 1'b0;
        live_data = rand_bus();
        live_data[0*W +: W] = 8'h45;
        live_data[8*W +: W] = 8'h12;
        frame_start = 1'b1;
        tick();
        check_val("idle_f0", 128'(disp_data[0*W +: W]), 128'h45);
        check_val("idle_f8", 128'(disp_data[8*W +: W]), 128'h00);
        check_val("idle_chg", 128'(mode_changed), 128'h0);

        // escribe beats crono
        escribe = 1'b1; crono = 1'b1;
        edit_data = rand_bus();
        tick();
        check_val("edit_mode", 128'(mode), 128'h1);
        check_val("edit_chg", 128'(mode_changed), 128'h1);
        check_val("edit_f9", 128'(disp_data[9*W +: W]), 128'h00);
        frame_start = 1'b0;
        tick();
        check_val("edit_chg_once", 128'(mode_changed), 128'h0);

        // RUN: live change between frames is held off until next frame_start
        escribe = 1'b0; crono = 1'b0; cr_activo = 1'b1;
        live_data[0*W +: W] = 8'h10;
        frame_start = 1'b1;
        tick();
        live_data[0*W +: W] = 8'h11;
        frame_start = 1'b0;
        tick();
        tick();
        check_val("run_hold", 128'(disp_data[0*W +: W]), 128'h10);
        frame_start = 1'b1;
        tick();
        check_val("run_upd", 128'(disp_data[0*W +: W]), 128'h11);

        // crono pulse that drops before frame_start is ignored
        frame_start = 1'b0;
        crono = 1'b1;
        repeat (5) tick();
        crono = 1'b0;
        frame_start = 1'b1;
        tick();
        check_val("pulse_mode", 128'(mode), 128'h3);
        check_val("pulse_chg", 128'(mode_changed), 128'h0);

        // Reset out of PROG, coincident frame_start does not load
        crono = 1'b1;
        prog_data = rand_bus() | {NF{8'h01}};
        tick();
        check_val("prog_mode", 128'(mode), 128'h2);
        reset = 1'b1;
        tick();
        check_val("prog_rst_disp", 128'(disp_data), 128'h0);
        check_val("prog_rst_mode", 128'(mode), 128'h0);
        reset = 1'b0;
        frame_start = 1'b0;
        tick();

`ifdef BLINK_EN
        // Cursor blank: frames 3-4 blanked with a period of 2
        reset = 1'b1; tick(); reset = 1'b0;
        escribe = 1'b1; crono = 1'b0; cursor = 8'd2;
        edit_data[2*W +: W] = 8'h37;
        frame_start = 1'b1;
        for (int fr = 1; fr <= 6; fr++) begin
            tick();
            check_val($sformatf("blink_fr%0d", fr), 128'(disp_data[2*W +: W]),
                      (fr == 3 || fr == 4) ? 128'hFF : 128'h37);
        end
        cursor = 8'd11;
        repeat (8) tick();
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset       = ($urandom_range(60) == 0);
            frame_start = ($urandom_range(3) == 0);
            escribe     = ($urandom_range(5) == 0);
            crono       = ($urandom_range(3) == 0);
            cr_activo   = ($urandom_range(1) == 1);
            if ($urandom_range(1) == 1) live_data = rand_bus();
            if ($urandom_range(2) == 0) edit_data = rand_bus();
            if ($urandom_range(2) == 0) prog_data = rand_bus();
            cursor = ($urandom_range(15) == 0) ? 8'hFF : 8'($urandom_range(12));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_frame_mux.md
# display_frame_mux

Frame-synchronous source selector for the RTC/timer VGA display. It picks the displayed value of each of NF fields from the live RTC, edit or timer-programming data, based on a prioritised mode. It registers the result so the VGA interface sees fields that stay constant for a whole frame. It sits between the RTC state machines and the VGA interface, and replaces the combinational mode mux in the top level with a registered, parametrised block that has mode tracking and cursor blinking.

## Interface
- W, 8, width of one display field (BCD byte).
- NF, 11, total number of fields; field i occupies bits [i*W +: W] of every bus.
- NT, 3, number of timer fields; fields NF-NT..NF-1 are timer, the rest are clock.
- BLINK_PERIOD, 30, frames per blink half-period (used only with BLINK_EN).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- escribe  in  1  edit-mode request (highest priority).
- crono  in  1  timer-programming request.
- cr_activo  in  1  timer-running request (lowest priority).
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- live_data  in  NF*W  current RTC/timer values read back from the chip.
- edit_data  in  NF*W  values being edited in the clock edit registers.
- prog_data  in  NF*W  values being programmed into the timer (only timer fields used).
- cursor  in  8  index of the field under edit.
- disp_data  out  NF*W  registered field values to the VGA interface.
- mode  out  2  displayed mode: 0 IDLE, 1 EDIT, 2 PROG, 3 RUN.
- mode_changed  out  1  one-cycle pulse when mode updates.

## Operation
- Requested mode is decoded every cycle with priority escribe > crono > cr_activo > none, giving EDIT, PROG, RUN or IDLE.
- The mode FSM has states IDLE, EDIT, PROG and RUN.
  - Transitions occur only on a cycle with frame_start=1.
  - On such a cycle, the state moves directly to the requested mode; any state can go to any state.
  - mode_changed pulses high for one cycle if the new state differs from the old one.
- Requests that toggle between frame_start pulses are ignored; only the value at the frame_start cycle counts.
- On every frame_start, all of disp_data is reloaded using the rule for the newly selected mode:
  - EDIT: clock fields from edit_data; timer fields 0.
  - PROG: clock fields from live_data; timer fields from prog_data.
  - RUN: all fields from live_data.
  - IDLE: clock fields from live_data; timer fields 0.
- Between frame_start pulses, disp_data and mode hold their values, even if source buses change.
- If a request change and frame_start arrive in the same cycle, the new mode and its data rule take effect together.
- Reset:
  - disp_data=0, mode=0 (IDLE), mode_changed=0; blink counter and phase cleared.
  - Reset mid-frame takes effect the next cycle.
  - The first frame_start after reset loads the data.
  - A frame_start coincident with reset is ignored.
- cursor ≥ NF selects no field.

## Timing
- frame_start at cycle n: disp_data, mode and mode_changed are valid at n+1.
- mode_changed is high only at n+1.
- Pipeline depth is one register; there is no combinational path from any input to any output.
- Back-to-back frame_start pulses (consecutive cycles) are each honoured and each reloads disp_data.

## Configuration
- BLINK_EN defined:
  - A frame counter increments on each frame_start and wraps from BLINK_PERIOD-1 to 0.
  - On wrap, blink_phase toggles.
  - In EDIT or PROG, when blink_phase=1 and cursor<NF, the reload forces field[cursor] to all ones (8'hFF, the blank code for the VGA interface).
  - In IDLE/RUN no field is forced.
- BLINK_EN undefined: no counter and no blink_phase; disp_data never shows a forced blank.

## Test plan
- Reset, then frame_start with no request and live_data field0=8'h45, field8=8'h12 -> next cycle disp_data field0=8'h45, field8=8'h00, mode=0, mode_changed=1 not asserted (IDLE→IDLE).
- escribe=1 and crono=1 together, frame_start -> mode=1, mode_changed=1 for exactly one cycle, fields 0..7 = edit_data, fields 8..10 = 0.
- In RUN, change live_data field0 from 8'h10 to 8'h11 between pulses -> disp_data stays 8'h10 until cycle after next frame_start, then 8'h11.
- crono pulsed high for 5 cycles between frame_starts, low at frame_start -> mode stays unchanged, no mode_changed.
- Assert reset for one cycle while in PROG with non-zero disp_data -> next cycle disp_data=0, mode=0; a frame_start coincident with reset produces no load.
- BLINK_EN, BLINK_PERIOD=2, EDIT, cursor=2 -> field2 = edit value for frames 1-2, 8'hFF for frames 3-4, edit value for frames 5-6; cursor=11 -> no field ever 8'hFF.
